vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Owns the single-port VRAM and shares it between three requesters: PPU fetcher, CPU, and a CGB-style VRAM DMA engine (HDMA1–HDMA5).
- Fixed priority, highest first: PPU during mode 3, then DMA, then CPU.
- The DMA copies 16-byte blocks from the system bus into VRAM. It runs either as one general transfer (GDMA) with the CPU stalled, or one block per H-blank (HDMA).
- Sits between the video block, the CPU bus decoder and the VRAM macro.

Parameters:
- BLOCK_BYTES, 16, bytes per DMA block (fixed; counters assume 16).

Ports:
- clk  in  1  system clock (4 MHz domain, same as video block)
- reset_n  in  1  synchronous active-low reset
- lcd_on  in  1  LCDC[7]
- mode  in  2  PPU STAT mode (00 hblank, 01 vblank, 10 oam, 11 transfer)
- ppu_rd  in  1  PPU VRAM fetch strobe
- ppu_addr  in  13  PPU VRAM address
- cpu_sel_vram  in  1  CPU cycle targets 0x8000–0x9FFF
- cpu_sel_hdma  in  1  CPU cycle targets 0xFF51–0xFF55, register chosen by cpu_addr[3:0]=1..5
- cpu_addr  in  13  CPU address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data (combinational)
- cpu_stall  out  1  hold CPU while DMA moves bytes
- src_rd  out  1  DMA source read strobe
- src_addr  out  16  DMA source address
- src_data  in  8  source data, valid the cycle after src_rd
- vram_addr  out  13  VRAM address
- vram_we  out  1  VRAM write enable
- vram_di  out  8  VRAM write data
- vram_data  in  8  VRAM read data for vram_addr (combinational)
- dma_active  out  1  DMA armed or running

Behaviour:

Reset (reset_n=0 at a clk edge):
- State goes to IDLE; src/dst/len registers clear.
- src_rd, vram_we, cpu_stall and dma_active all go to 0.
- HDMA5 reads 0xFF.

Registers (written only when cpu_sel_hdma and cpu_wr):
- HDMA1 = src[15:8]; HDMA2 = src[7:4], low nibble ignored.
- HDMA3 = dst[12:8], bits 7:5 ignored; HDMA4 = dst[7:4].
- HDMA1–HDMA4 read back 0xFF.
- HDMA5 write in IDLE: len := di[6:0] (blocks−1), byte_cnt := 0.
  - di[7]=0 → GDMA state.
  - di[7]=1 → HWAIT state.
- HDMA5 write with di[7]=0 while in HWAIT/HBLK: cancel. The in-flight byte completes, then state goes to IDLE; HDMA5 reads {1, len}.
- HDMA5 read: {~dma_active, len}. After normal completion len has wrapped to 0x7F, so the read is 0xFF.

State machine (IDLE, GDMA, HWAIT, HBLK):
- Each byte takes 2 cycles.
  - Phase A: src_rd=1, src_addr={src[15:4], byte_cnt}.
  - Phase B: vram_we=1, vram_di=src_data, vram_addr={dst[12:4], byte_cnt}.
- After phase B, byte_cnt increments. At byte_cnt 15→0:
  - src += 16.
  - dst[12:4] += 1, wrapping 0x1FF0 → 0x0000.
  - len decrements; if len was 0, state goes to IDLE.
- GDMA: runs back-to-back to completion; cpu_stall=1 for the whole state. Phase-B writes with lcd_on && mode==11 are suppressed (vram_we=0) but addresses still advance.
- HWAIT → HBLK on the cycle after mode changes into 00 with lcd_on=1. With lcd_on=0, HWAIT → HBLK immediately.
- HBLK: moves exactly one block (32 cycles) with cpu_stall=1, then returns to HWAIT (or IDLE when finished).
- An entry into H-blank while already in HBLK is ignored.
- Writing HDMA5 with di[7]=1 while HWAIT/HBLK is ignored.

VRAM mux (combinational), first match wins:
1. lcd_on && mode==11 && ppu_rd → vram_addr=ppu_addr, vram_we=0.
2. DMA phase B → DMA address/data as above.
3. Otherwise → vram_addr=cpu_addr, vram_we=cpu_wr && cpu_sel_vram && !cpu_blocked.

CPU access:
- cpu_blocked = lcd_on && mode==11.
- Blocked VRAM reads return 0xFF; blocked writes are dropped.
- cpu_do = vram_data for unblocked VRAM reads, the register value for HDMA reads, 0xFF otherwise.
- CPU strobes arriving while cpu_stall=1 are ignored.

Reset mid-transfer: aborts immediately with no further writes; all state returns to reset values.

Test Plan:
- Reset, then read HDMA5 → 0xFF, dma_active=0; all outputs 0.
- HDMA1..4 = 0xC0,0x05,0x81,0x23 (src 0xC000, dst 0x0120); write HDMA5=0x01 with mode=01 → 32 writes to VRAM 0x0120–0x013F over 64 cycles, cpu_stall high throughout, HDMA5 reads 0xFF at the end.
- HDMA5=0x82 with lcd_on=1 and mode cycling 10→11→00 three times → one 16-byte block per mode-00 entry, none during mode 11, idle after the third block.
- HDMA mode: after 1 of 3 blocks, CPU writes HDMA5=0x00 → no further VRAM writes; HDMA5 reads 0x81.
- dst=0x1FF0, 2 blocks GDMA → second block lands at 0x0000–0x000F.
- CPU VRAM read/write in mode 11 while ppu_rd=1 → cpu_do=0xFF, vram_we=0, vram_addr=ppu_addr; same access in mode 00 → write performed, read returns vram_data.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Owns the single-port VRAM. Arbitrates PPU fetches, CPU accesses
//             and a CGB-style VRAM DMA engine (HDMA1-HDMA5).
//             The fixed priority is PPU in mode 3, then DMA, then CPU.
//  Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lcd_on,
    input  logic [1:0]  mode,
    input  logic        ppu_rd,
    input  logic [12:0] ppu_addr,
    input  logic        cpu_sel_vram,
    input  logic        cpu_sel_hdma,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    output logic        cpu_stall,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [12:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_di,
    input  logic [7:0]  vram_data,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GDMA  = 2'd1,
        S_HWAIT = 2'd2,
        S_HBLK  = 2'd3
    } state_t;

    localparam logic [1:0] c_MODE_HBLANK   = 2'b00;
    localparam logic [1:0] c_MODE_TRANSFER = 2'b11;
    localparam logic [3:0] c_LAST_BYTE     = 4'(BLOCK_BYTES - 1);

    state_t      r_state;
    logic        r_phase;      // 0: source read, 1: VRAM write
    logic [3:0]  r_byte_cnt;
    logic [11:0] r_src;        // source address bits 15:4
    logic [8:0]  r_dst;        // destination address bits 12:4
    logic [6:0]  r_len;        // remaining blocks minus one
    logic [1:0]  r_mode_q;     // previous PPU mode, for H-blank entry detect

    logic w_cpu_blocked;
    logic w_moving;
    logic w_phase_b;
    logic w_cpu_wr;
    logic w_cpu_rd;
    logic w_hdma_wr;
    logic w_hdma5_wr;
    logic w_hblank_entry;

    assign w_cpu_blocked  = lcd_on && (mode == c_MODE_TRANSFER);
    assign w_moving       = (r_state == S_GDMA) || (r_state == S_HBLK);
    assign w_phase_b      = w_moving && r_phase;

    // The CPU is frozen while bytes move, so its strobes are masked here.
    assign w_cpu_wr       = cpu_wr && !cpu_stall;
    assign w_cpu_rd       = cpu_rd && !cpu_stall;
    assign w_hdma_wr      = cpu_sel_hdma && w_cpu_wr;
    assign w_hdma5_wr     = w_hdma_wr && (cpu_addr[3:0] == 4'd5);

    // With the LCD off there is no H-blank to wait for, so the gate is open.
    assign w_hblank_entry = lcd_on ? ((mode == c_MODE_HBLANK) && (r_mode_q != c_MODE_HBLANK))
                                   : 1'b1;

    assign cpu_stall  = w_moving;
    assign dma_active = (r_state != S_IDLE);
    assign src_rd     = w_moving && !r_phase;
    assign src_addr   = {r_src, r_byte_cnt};

    // DMA register file and transfer state machine.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_phase    <= 1'b0;
            r_byte_cnt <= 4'd0;
            r_src      <= 12'd0;
            r_dst      <= 9'd0;
            // Length sits at its post-completion value so HDMA5 reads 0xFF.
            r_len      <= 7'h7F;
            r_mode_q   <= 2'b00;
        end else begin
            r_mode_q <= mode;

            if (w_hdma_wr) begin
                case (cpu_addr[3:0])
                    4'd1:    r_src[11:4] <= cpu_di;
                    4'd2:    r_src[3:0]  <= cpu_di[7:4];
                    4'd3:    r_dst[8:4]  <= cpu_di[4:0];
                    4'd4:    r_dst[3:0]  <= cpu_di[7:4];
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hdma5_wr) begin
                        r_len      <= cpu_di[6:0];
                        r_byte_cnt <= 4'd0;
                        r_phase    <= 1'b0;
                        r_state    <= cpu_di[7] ? S_HWAIT : S_GDMA;
                    end
                end
                S_HWAIT: begin
                    // A cancel can only land here: HBLK stalls the CPU.
                    if (w_hdma5_wr && !cpu_di[7]) begin
                        r_state <= S_IDLE;
                    end else if (w_hblank_entry) begin
                        r_state <= S_HBLK;
                    end
                end
                S_GDMA, S_HBLK: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_src <= r_src + 12'd1;
                            r_dst <= r_dst + 9'd1;
                            r_len <= r_len - 7'd1;
                            if (r_len == 7'd0) begin
                                r_state <= S_IDLE;
                            end else if (r_state == S_HBLK) begin
                                r_state <= S_HWAIT;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // VRAM port mux: PPU in mode 3, then DMA write phase, then CPU.
    always_comb begin
        vram_addr = cpu_addr;
        vram_we   = cpu_sel_vram && w_cpu_wr && !w_cpu_blocked;
        vram_di   = cpu_di;
        if (w_cpu_blocked && ppu_rd) begin
            vram_addr = ppu_addr;
            vram_we   = 1'b0;
        end else if (w_phase_b) begin
            vram_addr = {r_dst, r_byte_cnt};
            // Addresses still advance while the PPU owns VRAM; only the write is lost.
            vram_we   = !w_cpu_blocked;
            vram_di   = src_data;
        end
    end

    // CPU read data: VRAM when reachable, HDMA5 status, else open bus.
    always_comb begin
        cpu_do = 8'hFF;
        if (w_cpu_rd && cpu_sel_vram && !w_cpu_blocked) begin
            cpu_do = vram_data;
        end else if (w_cpu_rd && cpu_sel_hdma && (cpu_addr[3:0] == 4'd5)) begin
            cpu_do = {~dma_active, r_len};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Self-checking bench for vram_arbiter. VRAM and the source bus
//             are modelled as arrays; expected DMA writes come from a
//             block/byte arithmetic model of the transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lcd_on;
    logic [1:0]  mode;
    logic        ppu_rd;
    logic [12:0] ppu_addr;
    logic        cpu_sel_vram;
    logic        cpu_sel_hdma;
    logic [12:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_stall;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [7:0]  src_data;
    logic [12:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_di;
    logic [7:0]  vram_data;
    logic        dma_active;

    int          n_vec = 0;
    int          n_err = 0;
    int          stall_cycles = 0;
    logic [7:0]  seed = 8'h3C;
    logic [7:0]  vram_mem [8192];
    logic [12:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    always #5 clk = ~clk;

    vram_arbiter #(.BLOCK_BYTES(16)) dut (
        .clk(clk), .reset_n(reset_n), .lcd_on(lcd_on), .mode(mode),
        .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
        .cpu_sel_vram(cpu_sel_vram), .cpu_sel_hdma(cpu_sel_hdma),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_di(cpu_di),
        .cpu_do(cpu_do), .cpu_stall(cpu_stall),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_di(vram_di),
        .vram_data(vram_data), .dma_active(dma_active)
    );

    // Source memory contents: a fixed scramble of the byte address.
    function automatic logic [7:0] src_fn(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'd29;
        return m[7:0] ^ a[15:8] ^ seed;
    endfunction

    assign vram_data = vram_mem[vram_addr];

    // Source bus responder: data for the requested address appears for the next cycle.
    always @(negedge clk) begin
        if (src_rd) src_data = src_fn(src_addr);
    end

    // VRAM macro model plus write log and stall counter.
    always @(negedge clk) begin
        if (vram_we) begin
            wr_addr.push_back(vram_addr);
            wr_data.push_back(vram_di);
            vram_mem[vram_addr] = vram_di;
        end
        if (cpu_stall) stall_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hdma_write(input logic [3:0] r, input logic [7:0] d);
        cpu_sel_hdma = 1'b1;
        cpu_addr     = {9'd0, r};
        cpu_wr       = 1'b1;
        cpu_di       = d;
        tick();
        cpu_sel_hdma = 1'b0;
        cpu_wr       = 1'b0;
    endtask

    task automatic hdma_read(input logic [3:0] r, output logic [7:0] d);
        cpu_sel_hdma = 1'b1;
        cpu_addr     = {9'd0, r};
        cpu_rd       = 1'b1;
        #1;
        d            = cpu_do;
        cpu_rd       = 1'b0;
        cpu_sel_hdma = 1'b0;
        #1;
    endtask

    // Program source/destination; the ignored bits carry random junk.
    task automatic set_regs(input logic [15:0] s, input logic [12:0] d);
        logic [7:0] junk;
        junk = 8'($urandom);
        hdma_write(4'd1, s[15:8]);
        hdma_write(4'd2, {s[7:4], junk[3:0]});
        hdma_write(4'd3, {junk[7:5], d[12:8]});
        hdma_write(4'd4, {d[7:4], junk[3:0]});
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        stall_cycles = 0;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int n;
        n = 0;
        while (dma_active && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, dma_active}, 32'd0);
    endtask

    // Expected: byte k of the transfer goes from src+k to (dst+k) mod 8 KiB.
    task automatic compare_writes(input logic [15:0] s, input logic [12:0] d, input int n, input string tag);
        int m;
        check_eq({tag, " count"}, wr_addr.size(), n);
        m = (wr_addr.size() < n) ? wr_addr.size() : n;
        for (int k = 0; k < m; k++) begin
            check_eq({tag, " addr"}, {19'd0, wr_addr[k]}, {19'd0, 13'(d + 13'(k))});
            check_eq({tag, " data"}, {24'd0, wr_data[k]}, {24'd0, src_fn(16'(s + 16'(k)))});
        end
    endtask

    task automatic phase(input logic [1:0] m, input int cycles);
        mode = m;
        repeat (cycles) tick();
    endtask

    initial begin
        logic [7:0]  rd;
        logic [15:0] s;
        logic [12:0] d;
        logic [12:0] ca;
        logic [12:0] pa;
        logic [7:0]  dv;
        int          blocks;
        int          n0;

        for (int i = 0; i < 8192; i++) vram_mem[i] = 8'h00;
        reset_n = 1'b0; lcd_on = 1'b0; mode = 2'b00; ppu_rd = 1'b0; ppu_addr = 13'd0;
        cpu_sel_vram = 1'b0; cpu_sel_hdma = 1'b0; cpu_addr = 13'd0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_di = 8'd0; src_data = 8'd0;

        // Reset state
        repeat (3) tick();
        check_eq("rst src_rd", {31'd0, src_rd}, 32'd0);
        check_eq("rst vram_we", {31'd0, vram_we}, 32'd0);
        check_eq("rst cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("rst dma_active", {31'd0, dma_active}, 32'd0);
        reset_n = 1'b1;
        tick();
        hdma_read(4'd5, rd);
        check_eq("rst hdma5", {24'd0, rd}, 32'hFF);
        hdma_read(4'd1, rd);
        check_eq("hdma1 readback", {24'd0, rd}, 32'hFF);

        // Directed GDMA: src 0xC000, dst 0x0120, 2 blocks
        lcd_on = 1'b1;
        mode   = 2'b01;
        hdma_write(4'd1, 8'hC0);
        hdma_write(4'd2, 8'h05);
        hdma_write(4'd3, 8'h81);
        hdma_write(4'd4, 8'h23);
        clear_log();
        hdma_write(4'd5, 8'h01);
        check_eq("gdma start active", {31'd0, dma_active}, 32'd1);
        wait_idle(200, "gdma timeout");
        check_eq("gdma stall cycles", stall_cycles, 64);
        compare_writes(16'hC000, 13'h0120, 32, "gdma");
        hdma_read(4'd5, rd);
        check_eq("gdma end hdma5", {24'd0, rd}, 32'hFF);

        // HDMA: 3 blocks, one per H-blank entry
        s = {12'($urandom), 4'h0};
        d = {9'($urandom), 4'h0};
        seed = 8'($urandom);
        set_regs(s, d);
        mode = 2'b10;
        clear_log();
        hdma_write(4'd5, 8'h82);
        for (int k = 0; k < 3; k++) begin
            phase(2'b10, 10);
            phase(2'b11, 20);
            check_eq("hdma no write outside hblank", wr_addr.size(), 16 * k);
            phase(2'b00, 50);
            check_eq("hdma block per hblank", wr_addr.size(), 16 * (k + 1));
        end
        check_eq("hdma done active", {31'd0, dma_active}, 32'd0);
        check_eq("hdma stall cycles", stall_cycles, 96);
        compare_writes(s, d, 48, "hdma");
        hdma_read(4'd5, rd);
        check_eq("hdma end hdma5", {24'd0, rd}, 32'hFF);

        // HDMA cancel after one block
        s = {12'($urandom), 4'h0};
        d = {9'($urandom), 4'h0};
        set_regs(s, d);
        mode = 2'b10;
        clear_log();
        hdma_write(4'd5, 8'h82);
        phase(2'b10, 10);
        phase(2'b11, 20);
        phase(2'b00, 50);
        phase(2'b10, 5);
        hdma_write(4'd5, 8'h00);
        for (int k = 0; k < 2; k++) begin
            phase(2'b11, 20);
            phase(2'b00, 50);
            phase(2'b10, 10);
        end
        compare_writes(s, d, 16, "cancel");
        check_eq("cancel active", {31'd0, dma_active}, 32'd0);
        hdma_read(4'd5, rd);
        check_eq("cancel hdma5", {24'd0, rd}, 32'h81);

        // Destination wrap at the top of VRAM
        s = {12'($urandom), 4'h0};
        set_regs(s, 13'h1FF0);
        mode = 2'b01;
        clear_log();
        hdma_write(4'd5, 8'h01);
        wait_idle(200, "wrap timeout");
        compare_writes(s, 13'h1FF0, 32, "wrap");

        // Randomized GDMA; writes vanish when the PPU owns VRAM (mode 3)
        for (int it = 0; it < 4; it++) begin
            s      = {12'($urandom), 4'h0};
            d      = {9'($urandom), 4'h0};
            blocks = $urandom_range(1, 3);
            seed   = 8'($urandom);
            set_regs(s, d);
            mode = 2'($urandom_range(0, 3));
            clear_log();
            hdma_write(4'd5, 8'(blocks - 1));
            wait_idle(300, "rand gdma timeout");
            check_eq("rand gdma stall", stall_cycles, 32 * blocks);
            compare_writes(s, d, (mode == 2'b11) ? 0 : 16 * blocks, "rand gdma");
            hdma_read(4'd5, rd);
            check_eq("rand gdma hdma5", {24'd0, rd}, 32'hFF);
        end

        // CPU access against PPU ownership
        for (int it = 0; it < 4; it++) begin
            ca = 13'($urandom);
            pa = 13'($urandom);
            dv = 8'($urandom);
            lcd_on = 1'b1; mode = 2'b11; ppu_rd = 1'b1; ppu_addr = pa;
            cpu_sel_vram = 1'b1; cpu_addr = ca; cpu_wr = 1'b1; cpu_di = dv;
            #1;
            check_eq("mode3 cpu wr we", {31'd0, vram_we}, 32'd0);
            check_eq("mode3 vram_addr", {19'd0, vram_addr}, {19'd0, pa});
            tick();
            cpu_wr = 1'b0; cpu_rd = 1'b1;
            #1;
            check_eq("mode3 cpu rd", {24'd0, cpu_do}, 32'hFF);
            cpu_rd = 1'b0;
            mode = 2'b00; cpu_wr = 1'b1;
            #1;
            check_eq("mode0 cpu wr we", {31'd0, vram_we}, 32'd1);
            check_eq("mode0 vram_addr", {19'd0, vram_addr}, {19'd0, ca});
            check_eq("mode0 vram_di", {24'd0, vram_di}, {24'd0, dv});
            tick();
            cpu_wr = 1'b0; cpu_rd = 1'b1;
            #1;
            check_eq("mode0 cpu rd", {24'd0, cpu_do}, {24'd0, dv});
            cpu_rd = 1'b0; cpu_sel_vram = 1'b0; ppu_rd = 1'b0;
            tick();
        end

        // Reset in the middle of a GDMA
        set_regs({12'($urandom), 4'h0}, {9'($urandom), 4'h0});
        mode = 2'b01;
        clear_log();
        hdma_write(4'd5, 8'h03);
        repeat (21) tick();
        reset_n = 1'b0;
        tick();
        n0 = wr_addr.size();
        check_eq("midrst active", {31'd0, dma_active}, 32'd0);
        check_eq("midrst stall", {31'd0, cpu_stall}, 32'd0);
        check_eq("midrst src_rd", {31'd0, src_rd}, 32'd0);
        check_eq("midrst vram_we", {31'd0, vram_we}, 32'd0);
        reset_n = 1'b1;
        repeat (100) tick();
        check_eq("midrst no writes", wr_addr.size(), n0);
        hdma_read(4'd5, rd);
        check_eq("midrst hdma5", {24'd0, rd}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
